exe_ctrl_wb_queue: RTL
======================

// Module: exe_ctrl_wb_queue
// PURPOSE
//  Completion-packet queue directly downstream of the single-cycle execution lane.
//  Accepts one control/completion packet per cycle from the lane's ctrl output.
//  Buffers packets in a DEPTH-entry FIFO and drains them in order to the active-list write port.
//  Decouples lane completion from active-list port stalls. All contents are discarded on recovery or exception.
// PARAMETERS
//  CTRL_W  64  width of a flattened ctrl packet (tag, PC/next-PC, flags)
//  DEPTH   4   FIFO entries; power of two, >= 2
//  CNT_W   16  width of the saturating stall counter
// PORTS
//  clk              in   1                 clock, rising edge
//  reset            in   1                 asynchronous, active-high
//  recoverFlag_i    in   1                 branch-recovery flush
//  exceptionFlag_i  in   1                 exception flush
//  ctrlValid_i      in   1                 lane presents a completion packet
//  ctrlData_i       in   CTRL_W            completion packet
//  ctrlReady_o      out  1                 queue can accept this cycle
//  alValid_o        out  1                 head packet valid toward active list
//  alData_o         out  CTRL_W            head packet
//  alReady_i        in   1                 active-list port accepts head this cycle
//  count_o          out  $clog2(DEPTH)+1   occupancy
//  dropErr_o        out  1                 sticky: valid offered while not ready
//  stallCycles_o    out  CNT_W             saturating count of alValid_o & !alReady_i cycles
// BEHAVIOUR
//  Reset (async, while reset=1)
//   - Pointers = 0; count_o = 0; alValid_o = 0; alData_o = 0.
//   - ctrlReady_o = 1; dropErr_o = 0; stallCycles_o = 0.
//   - Reset mid-operation discards all entries immediately.
//  Storage
//   - Circular buffer; rdPtr/wrPtr are $clog2(DEPTH) bits and wrap DEPTH-1 -> 0.
//   - count_o is a separate register.
//   - ctrlReady_o = (count_o != DEPTH), decoded from registered state only.
//   - alValid_o = (count_o != 0).
//   - alData_o = mem[rdPtr], combinational from registered state (no input-to-output path).
//  Handshakes
//   - push = ctrlValid_i & ctrlReady_o & !flush.
//   - pop  = alValid_o & alReady_i & !flush.
//   - push writes mem[wrPtr]; wrPtr++. pop advances rdPtr++.
//   - count_o += push - pop; simultaneous push and pop leaves count unchanged.
//   - Full: ctrlReady_o = 0 even if a pop occurs the same cycle (no same-cycle credit).
//   - Empty: a pushed packet first appears at alValid_o/alData_o the next cycle.
//     Minimum latency is 1 cycle; there is no fall-through.
//   - alData_o stays stable while alValid_o & !alReady_i.
//  Flush (flush = recoverFlag_i | exceptionFlag_i, sampled at the clock edge)
//   - Highest priority: rdPtr = wrPtr = 0; count_o = 0.
//   - A push or pop offered in the flush cycle is ignored.
//   - alValid_o = 0 from the next cycle. Memory contents need not be cleared.
//   - dropErr_o and stallCycles_o are NOT cleared by flush.
//  Error and statistics
//   - dropErr_o sets when ctrlValid_i & !ctrlReady_o & !flush; cleared only by reset.
//     The packet is lost; the lane must never do this.
//   - stallCycles_o increments each cycle alValid_o & !alReady_i & !flush.
//     It saturates at all-ones and never wraps.
// TESTING
//  1. Empty queue, push P=0xA5 at cycle 0, alReady_i=1
//     -> alValid_o=1, alData_o=0xA5 at cycle 1; count_o 1 -> 0 at cycle 2.
//  2. alReady_i=0, push 4 packets 1..4 on consecutive cycles
//     -> count_o=4, ctrlReady_o=0; a 5th valid sets dropErr_o=1.
//     Raising alReady_i then drains 1,2,3,4 in order, one per cycle.
//  3. count_o=2, push and pop in the same cycle
//     -> count_o stays 2; output order is preserved across the wrap after 8 ops.
//  4. count_o=3 plus a valid push in the flush cycle (recoverFlag_i=1)
//     -> count_o=0, alValid_o=0 next cycle; the pushed packet is never emitted.
//     The same holds for exceptionFlag_i.
//  5. Hold alValid_o=1, alReady_i=0 for 70000 cycles with CNT_W=16
//     -> stallCycles_o=0xFFFF and holds; alData_o is unchanged throughout.
//  6. Assert reset asynchronously mid-burst (count_o=3, between edges)
//     -> all outputs reach reset values immediately, before the next edge.

Source files
------------

// File: rtl/exe_ctrl_wb_queue_if.sv
// Valid/ready packet channel used on both sides of the completion-packet queue.
// The producer uses the master modport and the consumer uses the slave modport.
interface exe_ctrl_wb_queue_if #(
   parameter int W = 64
);
   logic         valid;
   logic [W-1:0] data;
   logic         ready;

   modport master (output valid, output data, input ready);
   modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/exe_ctrl_wb_queue.sv
// In-order completion-packet FIFO between the execution lane and the active-list write port.
// Recovery or exception flushes discard every entry; the error flag and stall statistics survive a flush.
module exe_ctrl_wb_queue #(
   parameter int CTRL_W = 64,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     recoverFlag_i,
   input  logic                     exceptionFlag_i,
   exe_ctrl_wb_queue_if.slave       ctrl,
   exe_ctrl_wb_queue_if.master      al,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     dropErr_o,
   output logic [CNT_W-1:0]         stallCycles_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = PTR_W + 1;

   logic [CTRL_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  rdPtr;
   logic [PTR_W-1:0]  wrPtr;
   logic [PTR_W-1:0]  rdPtrNxt;
   logic [PTR_W-1:0]  wrPtrNxt;
   logic [OCC_W-1:0]  countNxt;
   logic              dropErrNxt;
   logic [CNT_W-1:0]  stallNxt;

   logic flush;
   logic isFull;
   logic isEmpty;
   logic push;
   logic pop;

   // Ready and valid decode from registered occupancy only, so a pop never frees a slot in the same cycle.
   assign isFull     = (count_o == OCC_W'(DEPTH));
   assign isEmpty    = (count_o == '0);
   assign ctrl.ready = !isFull;
   assign al.valid   = !isEmpty;
   assign al.data    = mem[rdPtr];

   assign flush = recoverFlag_i | exceptionFlag_i;
   assign push  = ctrl.valid & !isFull & !flush;
   assign pop   = !isEmpty & al.ready & !flush;

   always_comb begin
      rdPtrNxt   = rdPtr;
      wrPtrNxt   = wrPtr;
      countNxt   = count_o;
      dropErrNxt = dropErr_o;
      stallNxt   = stallCycles_o;

      if (flush) begin
         rdPtrNxt = '0;
         wrPtrNxt = '0;
         countNxt = '0;
      end else begin
         if (push) begin
            wrPtrNxt = wrPtr + PTR_W'(1);
         end
         if (pop) begin
            rdPtrNxt = rdPtr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   countNxt = count_o + OCC_W'(1);
            2'b01:   countNxt = count_o - OCC_W'(1);
            default: countNxt = count_o;
         endcase
         if (ctrl.valid && isFull) begin
            dropErrNxt = 1'b1;
         end
         if (!isEmpty && !al.ready && (stallCycles_o != '1)) begin
            stallNxt = stallCycles_o + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdPtr         <= '0;
         wrPtr         <= '0;
         count_o       <= '0;
         dropErr_o     <= 1'b0;
         stallCycles_o <= '0;
      end else begin
         rdPtr         <= rdPtrNxt;
         wrPtr         <= wrPtrNxt;
         count_o       <= countNxt;
         dropErr_o     <= dropErrNxt;
         stallCycles_o <= stallNxt;
      end
   end

   // Storage is cleared on reset so the head data output reads zero while reset is held.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (push) begin
         mem[wrPtr] <= ctrl.data;
      end
   end

endmodule
